// File: rtl/snake_dir_input.sv
// Registered direction-input stage: synchronises and debounces four push buttons, decodes
// PS/2 arrow/WASD make codes, filters illegal turns and commits the queued direction on step.
module snake_dir_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int INIT_DIR        = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_key_data,
    input  logic        step,
    input  logic        clear,
    output logic [31:0] move,
    output logic [2:0]  pending,
    output logic        dir_changed
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       INIT_MOVE = 3'(INIT_DIR);

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } ps2_state_e;

    // Bit i carries direction code i+1, so index order is also arbitration order.
    logic [3:0] btn_raw;
    assign btn_raw = {left, down, right, up};

    logic [3:0]       sync1_q, sync2_q, deb_q, press_q;
    logic [CNT_W-1:0] cnt_q [4];

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values of its peers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        deb_q[i]   <= sync2_q[i];
                        cnt_q[i]   <= '0;
                        press_q[i] <= ~sync2_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    function automatic logic [2:0] wasd_dir(input logic [7:0] code);
        case (code)
            8'h1D:   return 3'd1;
            8'h23:   return 3'd2;
            8'h1B:   return 3'd3;
            8'h1C:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] arrow_dir(input logic [7:0] code);
        case (code)
            8'h75:   return 3'd1;
            8'h74:   return 3'd2;
            8'h72:   return 3'd3;
            8'h6B:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    ps2_state_e ps_state_q;
    logic [2:0] ps_evt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ps_state_q <= PS_IDLE;
            ps_evt_q   <= '0;
        end else if (clear) begin
            ps_state_q <= PS_IDLE;
            ps_evt_q   <= '0;
        end else begin
            ps_evt_q <= '0;
            if (ps2_key_pressed) begin
                case (ps_state_q)
                    PS_IDLE: begin
                        if (ps2_key_data == 8'hE0)      ps_state_q <= PS_EXT;
                        else if (ps2_key_data == 8'hF0) ps_state_q <= PS_BRK;
                        else                            ps_evt_q   <= wasd_dir(ps2_key_data);
                    end
                    PS_EXT: begin
                        if (ps2_key_data == 8'hF0) begin
                            ps_state_q <= PS_EXT_BRK;
                        end else begin
                            ps_evt_q   <= arrow_dir(ps2_key_data);
                            ps_state_q <= PS_IDLE;
                        end
                    end
                    default: ps_state_q <= PS_IDLE;
                endcase
            end
        end
    end

    logic [2:0] cand, eff, eff_rev;
    logic       commit, accept;
    logic [2:0] move_q, move_d, pending_q, pending_d;
    logic       dc_q, dc_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cand = ps_evt_q;
        for (int i = 3; i >= 0; i--) begin
            if (press_q[i]) cand = 3'(i + 1);
        end
        commit  = step && (pending_q != 3'd0);
        eff     = commit ? pending_q : move_q;
        eff_rev = (eff > 3'd2) ? eff - 3'd2 : eff + 3'd2;
        accept  = (cand != 3'd0) && (cand != eff) && (cand != eff_rev);

        move_d    = move_q;
        pending_d = pending_q;
        dc_d      = 1'b0;
        if (clear) begin
            move_d    = INIT_MOVE;
            pending_d = 3'd0;
        end else begin
            if (commit) begin
                move_d    = pending_q;
                pending_d = 3'd0;
                dc_d      = 1'b1;
            end
            if (accept) pending_d = cand;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            move_q    <= INIT_MOVE;
            pending_q <= 3'd0;
            dc_q      <= 1'b0;
        end else begin
            move_q    <= move_d;
            pending_q <= pending_d;
            dc_q      <= dc_d;
        end
    end

    assign move        = {29'd0, move_q};
    assign pending     = pending_q;
    assign dir_changed = dc_q;

endmodule
